// File: rtl/data_memory_kbd.sv
// rtl/data_memory_kbd.sv - word-addressed data RAM with an optional one-shot keyboard read port
// Optional feature macro: KEYBOARD_PORT_EN
module data_memory_kbd #(
  parameter int          ADDR_BITS = 14,
  parameter logic [31:0] KBD_ADDR  = 32'd16383
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        MemWrite,
  input  logic [31:0] WD,
  input  logic        sample,
  input  logic [7:0]  key_reg,
  output logic [31:0] RD
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [31:0]          mem_q [0:DEPTH-1];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          ram_rd;

  // Byte offset and upper address bits are dropped, so those addresses alias.
  assign idx    = addr[ADDR_BITS+1:2];
  assign ram_rd = mem_q[idx];

  always_ff @(posedge clk) begin
    if (MemWrite) begin
      mem_q[idx] <= WD;
    end
  end

`ifdef KEYBOARD_PORT_EN
  logic       read_kbd;
  logic [7:0] keyval_q, keyval_d;
  logic       dample_q, dample_d;

  assign read_kbd = (addr == KBD_ADDR) && !MemWrite;

  // A key is pending while sample differs from the last consumed level.
  always_comb begin
    keyval_d = 8'h00;
    dample_d = dample_q;
    if (read_kbd && (sample != dample_q)) begin
      keyval_d = key_reg;
      dample_d = sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyval_q <= 8'h00;
      dample_q <= 1'b1;
    end else begin
      keyval_q <= keyval_d;
      dample_q <= dample_d;
    end
  end

  assign RD = read_kbd ? {24'h0, keyval_q} : ram_rd;
`else
  logic unused_inputs;
  assign unused_inputs = ^{rst, sample, key_reg, addr[31:ADDR_BITS+2], addr[1:0], KBD_ADDR};
  assign RD = ram_rd;
`endif

endmodule

// File: tb/tb_data_memory_kbd.sv
// tb/tb_data_memory_kbd.sv - randomized self-checking bench for data_memory_kbd
// Keyboard scenarios compiled in when KEYBOARD_PORT_EN is defined
module tb_data_memory_kbd;

  localparam logic [31:0] KBD = 32'd16383;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        MemWrite;
  logic [31:0] WD;
  logic        sample;
  logic [7:0]  key_reg;
  logic [31:0] RD;

  int total = 0;
  int bad   = 0;

  // Reference: RAM as a sparse word map, keyboard as last consumed level plus delivered code.
  logic [31:0] ref_mem [int];
  logic        ref_level;
  logic [7:0]  ref_code;

  data_memory_kbd dut (
    .clk(clk), .rst(rst), .addr(addr), .MemWrite(MemWrite), .WD(WD),
    .sample(sample), .key_reg(key_reg), .RD(RD)
  );

  always #5 clk = ~clk;

  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % 16384);
  endfunction

  function automatic bit is_kbd_read();
`ifdef KEYBOARD_PORT_EN
    return (addr == KBD) && !MemWrite;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit known();
    return is_kbd_read() || ref_mem.exists(widx(addr));
  endfunction

  function automatic logic [31:0] exp_rd();
    if (is_kbd_read()) return {24'h0, ref_code};
    return ref_mem[widx(addr)];
  endfunction

  // One clock edge; the model consumes the inputs presented before it.
  task automatic step();
    bit kr;
    kr = is_kbd_read();
    if (MemWrite) ref_mem[widx(addr)] = WD;
    @(posedge clk);
    if (rst) begin
      ref_code  = 8'h00;
      ref_level = 1'b1;
    end else if (kr && (sample != ref_level)) begin
      ref_code  = key_reg;
      ref_level = sample;
    end else begin
      ref_code  = 8'h00;
    end
    #1;
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d);
    addr = a; WD = d; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic check_rd(string name, logic [31:0] a, logic [31:0] exp);
    addr = a; MemWrite = 1'b0;
    #1;
    total++;
    if (RD !== exp) begin
      bad++;
      $display("FAIL %s addr=%h RD=%h expected=%h", name, a, RD, exp);
    end
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    ref_code = 8'h00; ref_level = 1'b1;
    step();
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = 32'h0; MemWrite = 1'b0; WD = 32'h0; sample = 1'b0; key_reg = 8'h00;
    ref_code = 8'h00; ref_level = 1'b1;
    step();
`ifdef KEYBOARD_PORT_EN
    check_rd("reset_kbd_zero", KBD, 32'h0);
`endif
    #2 rst = 1'b0;
    do_write(32'h0, 32'h1357_9BDF);
    apply_reset();
    check_rd("reset_keeps_ram", 32'h0, 32'h1357_9BDF);
  endtask

  task automatic test_write_readback();
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    check_rd("readback", 32'h0000_0010, 32'hDEAD_BEEF);
    check_rd("byte_alias", 32'h0000_0013, 32'hDEAD_BEEF);
  endtask

  task automatic test_isolation();
    do_write(32'h0, 32'h1111_1111);
    do_write(32'h4, 32'h2222_2222);
    check_rd("iso_word0", 32'h0, 32'h1111_1111);
    check_rd("iso_word1", 32'h4, 32'h2222_2222);
  endtask

  task automatic test_upper_alias();
    do_write(32'h0001_0008, 32'hA5A5_A5A5);
    check_rd("upper_alias", 32'h0000_0008, 32'hA5A5_A5A5);
  endtask

  task automatic test_read_during_write();
    addr = 32'h0000_0010; WD = 32'h0BAD_F00D; MemWrite = 1'b1;
    #1;
    total++;
    if (RD !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rdw_old RD=%h expected=%h", RD, 32'hDEAD_BEEF);
    end
    step();
    MemWrite = 1'b0;
    check_rd("rdw_new", 32'h0000_0010, 32'h0BAD_F00D);
  endtask

  task automatic test_random_ram();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 63) * 4) | $urandom_range(0, 3) | ({$urandom} & 32'hFFFF_0000);
      if ($urandom_range(0, 2) == 0) begin
        do_write(a, $urandom);
      end else begin
        addr = a; MemWrite = 1'b0;
        #1;
        if (known()) begin
          total++;
          if (RD !== exp_rd()) begin
            bad++;
            $display("FAIL rand_ram addr=%h RD=%h expected=%h", a, RD, exp_rd());
          end
        end
        step();
      end
    end
  endtask

`ifdef KEYBOARD_PORT_EN
  task automatic test_kbd_oneshot();
    sample = 1'b0; key_reg = 8'h41;
    apply_reset();
    check_rd("kbd_c0", KBD, 32'h0);
    step();
    check_rd("kbd_c1", KBD, 32'h41);
    step();
    check_rd("kbd_c2", KBD, 32'h0);
    step();
    check_rd("kbd_c3", KBD, 32'h0);
    sample = 1'b1; key_reg = 8'h42;
    step();
    check_rd("kbd_k2", KBD, 32'h42);
    step();
    check_rd("kbd_k2_once", KBD, 32'h0);
  endtask

  task automatic test_kbd_write_at_port();
    sample = ~ref_level; key_reg = 8'h5A;
    do_write(KBD, 32'h77);
    check_rd("kbdw_no_capture", KBD, 32'h0);
    step();
    check_rd("kbdw_key_kept", KBD, 32'h5A);
    check_rd("kbdw_ram", 32'h0000_3FFC, 32'h77);
  endtask

  task automatic test_kbd_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) sample = ~sample;
      key_reg  = 8'($urandom);
      MemWrite = ($urandom_range(0, 9) == 0);
      WD       = $urandom;
      addr     = ($urandom_range(0, 9) < 6) ? KBD : 32'(4 * $urandom_range(0, 5));
      #1;
      if (known()) begin
        total++;
        if (RD !== exp_rd()) begin
          bad++;
          $display("FAIL rand_kbd cyc=%0d addr=%h RD=%h expected=%h", i, addr, RD, exp_rd());
        end
      end
      step();
    end
    MemWrite = 1'b0;
  endtask

  task automatic test_async_reset();
    do_write(32'h0, 32'h1111_1111);
    sample = 1'b0; key_reg = 8'h41;
    apply_reset();
    addr = KBD;
    step();
    check_rd("areset_key_visible", KBD, 32'h41);
    rst = 1'b1;
    check_rd("areset_immediate", KBD, 32'h0);
    ref_code = 8'h00; ref_level = 1'b1;
    step();
    #2 rst = 1'b0;
    check_rd("areset_ram_kept", 32'h0, 32'h1111_1111);
  endtask
`else
  task automatic test_kbd_disabled();
    do_write(KBD, 32'h77);
    for (int i = 0; i < 4; i++) begin
      sample = ~sample; key_reg = 8'($urandom);
      check_rd("nokbd_plain_ram", KBD, 32'h77);
      step();
    end
    check_rd("nokbd_alias", 32'h0000_3FFC, 32'h77);
  endtask
`endif

  initial begin
    test_reset();
    test_write_readback();
    test_isolation();
    test_upper_alias();
    test_read_during_write();
    test_random_ram();
`ifdef KEYBOARD_PORT_EN
    test_kbd_oneshot();
    test_kbd_write_at_port();
    test_kbd_random();
    test_async_reset();
`else
    test_kbd_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_kbd.md
Name: data_memory_kbd

Overview:
- Word-addressed data memory for the multicycle processor, with one memory-mapped keyboard input port.
- Decodes a byte address to a word, writes synchronously and reads combinationally.
- A read of the keyboard address returns a one-shot keyboard code instead of RAM data.
- Sits on the processor's data bus, replacing a plain RAM.

Parameters:
- ADDR_BITS, 14, word-index width; depth = 2**ADDR_BITS words of 32 bits.
- KBD_ADDR, 32'd16383, full 32-bit byte address of the keyboard port (exact compare, not word-aligned).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  32  byte address; word index = addr[ADDR_BITS+1:2].
- MemWrite  input  1  write enable.
- WD  input  32  write data.
- sample  input  1  keyboard toggle; a level change marks a new key.
- key_reg  input  8  current keyboard code.
- RD  output  32  read data (combinational).

Behaviour:
- Reset is asynchronous and active-high.
  - On rst: keyVal <= 8'h00, dample <= 1'b1.
  - RAM contents are not affected by reset.
  - Unwritten words read as X in simulation; the bench must write a word before reading it.
- Word index idx = addr[ADDR_BITS+1:2].
  - addr[1:0] and addr[31:ADDR_BITS+2] are ignored, so aliasing is intended.
- Write: at a rising clk edge with MemWrite=1, mem[idx] <= WD.
  - Exactly one word is written (one-hot decode of idx).
  - Writes to KBD_ADDR go to RAM word idx = KBD_ADDR[ADDR_BITS+1:2], which is word 4095 by default.
- RAM read: combinational, ram_rd = mem[idx].
  - A read in the same cycle as a write to the same word returns the old value; the new value appears after the edge.
- readKeyboard = (addr == KBD_ADDR) && (MemWrite == 0). Combinational.
- Keyboard register, updated at each rising clk edge when not in reset:
  - If readKeyboard and sample != dample: keyVal <= key_reg, dample <= sample.
  - Otherwise: keyVal <= 0, dample unchanged.
- Output: RD = readKeyboard ? {24'h0, keyVal} : ram_rd.
- Keyboard timing while addr is held at KBD_ADDR for consecutive cycles:
  - First cycle returns 0 (keyVal was cleared by the preceding non-keyboard cycle).
  - If a new key was pending, the next cycle returns the key code.
  - After that it returns 0 until sample toggles again, so each key is delivered exactly once.
- A sample toggle while the keyboard is not being read is remembered. It is consumed at the first keyboard-read edge because dample only updates then.
- Two toggles between keyboard reads cancel out (sample == dample again), so that key is lost. This is accepted behaviour.
- After reset dample=1, so sample=0 at the first keyboard read counts as a pending key.
- rst asserted mid-read forces keyVal=0 immediately; RD then shows 0 while addr==KBD_ADDR.

Optional Feature:
- Macro KEYBOARD_PORT_EN.
- Defined: keyboard register, readKeyboard compare and output 2:1 select are present, as described above.
- Undefined:
  - RD = ram_rd always.
  - sample and key_reg are ignored.
  - No keyVal/dample state exists.
  - KBD_ADDR behaves as an ordinary RAM address.

Test Plan:
- Write/readback: MemWrite=1, addr=32'h0000_0010, WD=32'hDEAD_BEEF, one edge; then MemWrite=0 -> RD=32'hDEAD_BEEF. Also addr=32'h0000_0013 -> RD=32'hDEAD_BEEF (byte-offset alias).
- Isolation: write 32'h1111_1111 to addr 0 and 32'h2222_2222 to addr 4. Read addr 0 -> 32'h1111_1111; read addr 4 -> 32'h2222_2222; word 0 is not overwritten by the second write.
- Upper-bit alias: write 32'hA5A5_A5A5 at addr 32'h0001_0008 -> read at addr 32'h0000_0008 returns 32'hA5A5_A5A5.
- Keyboard one-shot (KEYBOARD_PORT_EN): reset, sample=0, key_reg=8'h41, hold addr=16383, MemWrite=0. RD = 0 in cycle 0, 32'h41 in cycle 1, 0 in cycle 2 onward. Toggle sample to 1 with key_reg=8'h42 -> RD=32'h42 for exactly one cycle.
- Write at KBD_ADDR: MemWrite=1, addr=16383, WD=32'h77 -> no keyboard capture. A subsequent read at addr 32'h0000_3FFC returns 32'h77.
- Async reset: with keyVal=8'h41 visible on RD, assert rst between clock edges -> RD drops to 0 without waiting for a clock edge. RAM word 0 keeps 32'h1111_1111 after reset.
